// File: rtl/vu_vxu_banked8_viu_seq_pkg.sv
// Shared configuration for the banked VIU element sequencer: default widths
// and the sequencer state encoding.
package vu_vxu_banked8_viu_seq_pkg;

  // Element index / vector-length width (utidx).
  localparam int SZ_VLEN_DEF = 8;

  // VIU function word width (fn, fp and dw fields packed together).
  localparam int SZ_FN_DEF = 11;

  // Sequencer states: waiting for an op, issuing elements, final writeback.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/vu_vxu_banked8_viu_seq.sv
// Banked VIU element sequencer: accepts one vector op, issues elements
// 0..vlen_m1 to the external ALU one per non-stalled cycle, tracks the
// registered ALU writeback and counts the elements actually written.
module vu_vxu_banked8_viu_seq
  import vu_vxu_banked8_viu_seq_pkg::*;
#(
  parameter int SZ_VLEN = SZ_VLEN_DEF,
  parameter int SZ_FN   = SZ_FN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_val,
  output logic               issue_rdy,
  input  logic [SZ_FN-1:0]   issue_fn,
  input  logic [SZ_VLEN-1:0] issue_vlen_m1,
  input  logic               issue_wen,
  input  logic               stall,
  output logic               seq_val,
  output logic               seq_wen,
  output logic [SZ_FN-1:0]   seq_fn,
  output logic [SZ_VLEN-1:0] seq_utidx,
  input  logic               alu_wen_masked,
  output logic               wb_val,
  output logic [SZ_VLEN-1:0] wb_utidx,
  output logic               done,
  output logic [SZ_VLEN:0]   wr_count
);

  seq_state_e         state_q, state_d;
  logic [SZ_FN-1:0]   fn_q, fn_d;
  logic [SZ_VLEN-1:0] vlen_m1_q, vlen_m1_d;
  logic               wen_q, wen_d;
  logic [SZ_VLEN-1:0] utidx_q, utidx_d;
  logic               wb_val_q, wb_val_d;
  logic [SZ_VLEN-1:0] wb_utidx_q, wb_utidx_d;
  logic [SZ_VLEN:0]   wr_cnt_q, wr_cnt_d;
  logic               wb_fire;
  logic [SZ_VLEN:0]   wr_sum;

  // Outputs; all are forced to their idle values while reset is held low so
  // the block looks idle for the whole reset window, not only after the edge.
  always_comb begin
    issue_rdy = ~reset | (state_q == ST_IDLE);
    seq_val   = reset & (state_q == ST_RUN) & ~stall;
    seq_wen   = seq_val & wen_q;
    seq_fn    = fn_q;
    seq_utidx = utidx_q;
    wb_val    = reset & wb_val_q;
    wb_utidx  = wb_utidx_q;
    done      = reset & (state_q == ST_DRAIN);
    wb_fire   = wb_val_q & alu_wen_masked;
    wr_sum    = wr_cnt_q + {{SZ_VLEN{1'b0}}, wb_fire};
    wr_count  = reset ? wr_sum : '0;
  end

  // Next-state logic: accept in IDLE, step utidx on non-stalled RUN cycles,
  // leave RUN on the last element (equality compare, so a full-range length
  // never wraps), and spend one DRAIN cycle for the final writeback.
  always_comb begin
    state_d    = state_q;
    fn_d       = fn_q;
    vlen_m1_d  = vlen_m1_q;
    wen_d      = wen_q;
    utidx_d    = utidx_q;
    wb_val_d   = seq_val;
    wb_utidx_d = utidx_q;
    wr_cnt_d   = wr_sum;
    unique case (state_q)
      ST_IDLE: begin
        if (issue_val) begin
          fn_d      = issue_fn;
          vlen_m1_d = issue_vlen_m1;
          wen_d     = issue_wen;
          utidx_d   = '0;
          wr_cnt_d  = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (utidx_q == vlen_m1_q) begin
            state_d = ST_DRAIN;
          end else begin
            utidx_d = utidx_q + SZ_VLEN'(1);
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fn_q       <= '0;
      vlen_m1_q  <= '0;
      wen_q      <= 1'b0;
      utidx_q    <= '0;
      wb_val_q   <= 1'b0;
      wb_utidx_q <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      fn_q       <= fn_d;
      vlen_m1_q  <= vlen_m1_d;
      wen_q      <= wen_d;
      utidx_q    <= utidx_d;
      wb_val_q   <= wb_val_d;
      wb_utidx_q <= wb_utidx_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

endmodule

// File: tb/tb_vu_vxu_banked8_viu_seq.sv
// Directed bench for the banked VIU sequencer: a table of ops with
// hand-computed latency and write counts, plus reset-abort sequences.
module tb_vu_vxu_banked8_viu_seq;

  typedef struct {
    logic [7:0]  vlen_m1;
    logic        wen;
    logic [10:0] fn;
    logic [15:0] stall_pat;
    logic [15:0] mask_pat;
    logic        hold_issue;
    int          exp_done;
    int          exp_wr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_val;
  logic        issue_rdy;
  logic [10:0] issue_fn;
  logic [7:0]  issue_vlen_m1;
  logic        issue_wen;
  logic        stall;
  logic        seq_val;
  logic        seq_wen;
  logic [10:0] seq_fn;
  logic [7:0]  seq_utidx;
  logic        alu_wen_masked;
  logic        wb_val;
  logic [7:0]  wb_utidx;
  logic        done;
  logic [8:0]  wr_count;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[6];

  vu_vxu_banked8_viu_seq dut (
    .clk            (clk),
    .reset          (reset),
    .issue_val      (issue_val),
    .issue_rdy      (issue_rdy),
    .issue_fn       (issue_fn),
    .issue_vlen_m1  (issue_vlen_m1),
    .issue_wen      (issue_wen),
    .stall          (stall),
    .seq_val        (seq_val),
    .seq_wen        (seq_wen),
    .seq_fn         (seq_fn),
    .seq_utidx      (seq_utidx),
    .alu_wen_masked (alu_wen_masked),
    .wb_val         (wb_val),
    .wb_utidx       (wb_utidx),
    .done           (done),
    .wr_count       (wr_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Runs one op from IDLE to the cycle after done, checking every issue and
  // writeback along the way.
  task automatic applyStimulus(input vec_t v, input int idx);
    int cyc;
    int nissue;
    int nwb;
    int seq_err;
    int wb_err;
    int rdy_busy;
    logic finished;
    checkOutput($sformatf("v%0d_idle_rdy", idx), issue_rdy, 1);
    issue_val      = 1'b1;
    issue_fn       = v.fn;
    issue_vlen_m1  = v.vlen_m1;
    issue_wen      = v.wen;
    stall          = 1'b0;
    alu_wen_masked = 1'b0;
    @(posedge clk); #1;
    if (v.hold_issue) begin
      issue_fn      = ~v.fn;
      issue_vlen_m1 = 8'd7;
      issue_wen     = ~v.wen;
    end else begin
      issue_val = 1'b0;
    end
    cyc = 1; nissue = 0; nwb = 0; seq_err = 0; wb_err = 0; rdy_busy = 0;
    finished = 1'b0;
    while (!finished && cyc <= 400) begin
      stall          = (cyc <= 16) ? v.stall_pat[cyc-1] : 1'b0;
      alu_wen_masked = v.mask_pat[nwb % 16];
      #1;
      if (issue_rdy) rdy_busy++;
      if (stall && seq_val) seq_err++;
      if (seq_val) begin
        if (seq_utidx !== nissue[7:0] || seq_wen !== v.wen || seq_fn !== v.fn) seq_err++;
        nissue++;
      end
      if (wb_val) begin
        if (wb_utidx !== nwb[7:0]) wb_err++;
        nwb++;
      end
      if (done) begin
        finished = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    checkOutput($sformatf("v%0d_done_seen", idx), finished, 1);
    checkOutput($sformatf("v%0d_done_latency", idx), cyc, v.exp_done);
    checkOutput($sformatf("v%0d_wr_count", idx), wr_count, v.exp_wr);
    checkOutput($sformatf("v%0d_issues", idx), nissue, int'(v.vlen_m1) + 1);
    checkOutput($sformatf("v%0d_wbs", idx), nwb, int'(v.vlen_m1) + 1);
    checkOutput($sformatf("v%0d_seq_errs", idx), seq_err, 0);
    checkOutput($sformatf("v%0d_wb_errs", idx), wb_err, 0);
    checkOutput($sformatf("v%0d_rdy_busy", idx), rdy_busy, 0);
    issue_val      = 1'b0;
    stall          = 1'b0;
    alu_wen_masked = 1'b0;
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d_post_done", idx), done, 0);
    checkOutput($sformatf("v%0d_post_rdy", idx), issue_rdy, 1);
  endtask

  // Main sequence: reset, reset-abort corner cases, then the vector table.
  initial begin
    vecs[0] = '{8'd3,   1'b1, 11'h5A3, 16'h0000, 16'hFFFF, 1'b0, 5,   4};
    vecs[1] = '{8'd4,   1'b1, 11'h123, 16'h0006, 16'hFFFF, 1'b0, 8,   5};
    vecs[2] = '{8'd3,   1'b1, 11'h040, 16'h0000, 16'h0005, 1'b0, 5,   2};
    vecs[3] = '{8'd0,   1'b0, 11'h7FF, 16'h0000, 16'hFFFF, 1'b1, 2,   1};
    vecs[4] = '{8'd255, 1'b1, 11'h2AA, 16'h0000, 16'hFFFF, 1'b0, 257, 256};
    vecs[5] = '{8'd2,   1'b1, 11'h3C1, 16'h0005, 16'h0006, 1'b0, 6,   2};

    reset = 1'b0; issue_val = 1'b1; issue_fn = 11'h155; issue_vlen_m1 = 8'd9;
    issue_wen = 1'b1; stall = 1'b0; alu_wen_masked = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_issue_rdy", issue_rdy, 1);
    checkOutput("rst_seq_val", seq_val, 0);
    checkOutput("rst_seq_wen", seq_wen, 0);
    checkOutput("rst_wb_val", wb_val, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_wr_count", wr_count, 0);
    @(posedge clk); #1;
    reset = 1'b1; issue_val = 1'b0; alu_wen_masked = 1'b0;
    #1;
    checkOutput("post_rst_issue_rdy", issue_rdy, 1);
    checkOutput("post_rst_seq_val", seq_val, 0);
    checkOutput("post_rst_wb_val", wb_val, 0);
    checkOutput("post_rst_done", done, 0);
    checkOutput("post_rst_wr_count", wr_count, 0);
    checkOutput("post_rst_seq_fn", seq_fn, 0);
    checkOutput("post_rst_utidx", seq_utidx, 0);

    // Abort in the RUN cycle that issues utidx 2.
    @(posedge clk); #1;
    issue_val = 1'b1; issue_fn = 11'h003; issue_vlen_m1 = 8'd5; issue_wen = 1'b1;
    @(posedge clk); #1;
    issue_val = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("abort_run_utidx", seq_utidx, 2);
    reset = 1'b0;
    #1;
    checkOutput("abort_run_done", done, 0);
    checkOutput("abort_run_wb_val", wb_val, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput("abort_run_rdy", issue_rdy, 1);
    checkOutput("abort_run_seq_val", seq_val, 0);
    checkOutput("abort_run_wb_val2", wb_val, 0);
    checkOutput("abort_run_done2", done, 0);
    checkOutput("abort_run_utidx0", seq_utidx, 0);
    applyStimulus(vecs[0], 90);

    // Abort in the DRAIN cycle of a single-element op.
    issue_val = 1'b1; issue_fn = 11'h011; issue_vlen_m1 = 8'd0; issue_wen = 1'b1;
    @(posedge clk); #1;
    issue_val = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_drain_in_drain", done, 1);
    reset = 1'b0;
    #1;
    checkOutput("abort_drain_done", done, 0);
    checkOutput("abort_drain_wb_val", wb_val, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput("abort_drain_rdy", issue_rdy, 1);
    checkOutput("abort_drain_done2", done, 0);
    checkOutput("abort_drain_wb_val2", wb_val, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], i);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
